// File: rtl/sync_fifo_mem_pkg.sv
// Shared types and helpers for the sync_fifo_mem storage block.
// The FIFO depth need not be a power of two, so pointer wrap uses an explicit compare.
package fifo_pkg;

   typedef enum logic {FIFO_REG = 1'b0, FIFO_FWFT = 1'b1} fifo_mode_e;

   localparam int CNT_W = 32;
   typedef logic [CNT_W-1:0] count_t;

   function automatic count_t next_ptr(input count_t ptr, input count_t depth);
      return (ptr == depth - 1) ? '0 : ptr + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_mem_if.sv
// Producer/consumer bus of sync_fifo_mem.
// The master side drives requests; the slave side is the FIFO itself.
interface sync_fifo_mem_if #(
   parameter int DATA_WIDTH = 8,
   parameter int MEM_DEPTH  = 16
);
   localparam int PTR_WIDTH = $clog2(MEM_DEPTH);

   logic                  W_EN;
   logic [DATA_WIDTH-1:0] I_DATA;
   logic                  R_EN;
   logic                  CLR_ERR;
   logic [DATA_WIDTH-1:0] O_DATA;
   logic                  O_VALID;
   logic                  FULL;
   logic                  EMPTY;
   logic                  ALMOST_FULL;
   logic                  ALMOST_EMPTY;
   logic [PTR_WIDTH:0]    COUNT;
   logic                  OVERFLOW;
   logic                  UNDERFLOW;

   modport master (
      output W_EN, I_DATA, R_EN, CLR_ERR,
      input  O_DATA, O_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVERFLOW, UNDERFLOW
   );

   modport slave (
      input  W_EN, I_DATA, R_EN, CLR_ERR,
      output O_DATA, O_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVERFLOW, UNDERFLOW
   );
endinterface

// File: rtl/sync_fifo_mem_ptr_wrap.sv
// FIFO address pointer: advances by one on inc_i, wraps MEM_DEPTH-1 -> 0.
// Used for both the write and the read pointer.
module fifo_ptr_wrap
   import fifo_pkg::*;
#(
   parameter int PTR_WIDTH = 4,
   parameter int MEM_DEPTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 inc_i,
   output logic [PTR_WIDTH-1:0] ptr_o
);
   logic [PTR_WIDTH-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (inc_i) ptr_d = PTR_WIDTH'(next_ptr(count_t'(ptr_q), count_t'(MEM_DEPTH)));
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end

   assign ptr_o = ptr_q;
endmodule

// File: rtl/sync_fifo_mem.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky error flags
// and a choice of registered or first-word-fall-through read.
module sync_fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int MEM_DEPTH     = 16,
   parameter int AFULL_THRESH  = MEM_DEPTH - 2,
   parameter int AEMPTY_THRESH = 2,
   parameter int FWFT          = 0
) (
   input logic            CLK,
   input logic            RST_N,
   sync_fifo_mem_if.slave bus
);
   localparam int PTR_WIDTH = $clog2(MEM_DEPTH);
   localparam int CW        = PTR_WIDTH + 1;
   localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_REG;
   localparam logic [CW-1:0] DEPTH_C  = CW'(MEM_DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
   logic [PTR_WIDTH-1:0]  wptr, rptr;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] odata_q;
   logic                  ovalid_q, ovf_q, unf_q;
   logic                  empty, full, rd_ok, wr_ok;

   assign empty = (count_q == '0);
   assign full  = (count_q == DEPTH_C);
   assign rd_ok = bus.R_EN & ~empty;
   // A write into a full FIFO is fine when a read frees a slot in the same cycle.
   assign wr_ok = bus.W_EN & (~full | rd_ok);

   fifo_ptr_wrap #(.PTR_WIDTH(PTR_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_wptr (
      .clk_i(CLK), .rst_ni(RST_N), .inc_i(wr_ok), .ptr_o(wptr)
   );

   fifo_ptr_wrap #(.PTR_WIDTH(PTR_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_rptr (
      .clk_i(CLK), .rst_ni(RST_N), .inc_i(rd_ok), .ptr_o(rptr)
   );

   always_comb begin
      count_d = count_q;
      if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
      else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (wr_ok) mem_q[wptr] <= bus.I_DATA;
   end

   // Error flags: a new rejection in the same cycle as CLR_ERR keeps the flag set.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         count_q  <= '0;
         odata_q  <= '0;
         ovalid_q <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         count_q  <= count_d;
         ovalid_q <= rd_ok;
         if (rd_ok) odata_q <= mem_q[rptr];
         ovf_q    <= (bus.W_EN & ~wr_ok) | (~bus.CLR_ERR & ovf_q);
         unf_q    <= (bus.R_EN & ~rd_ok) | (~bus.CLR_ERR & unf_q);
      end
   end

   assign bus.O_DATA       = (MODE == FIFO_FWFT) ? mem_q[rptr] : odata_q;
   assign bus.O_VALID      = (MODE == FIFO_FWFT) ? ~empty : ovalid_q;
   assign bus.FULL         = full;
   assign bus.EMPTY        = empty;
   assign bus.ALMOST_FULL  = (count_q >= AFULL_C);
   assign bus.ALMOST_EMPTY = (count_q <= AEMPTY_C);
   assign bus.COUNT        = count_q;
   assign bus.OVERFLOW     = ovf_q;
   assign bus.UNDERFLOW    = unf_q;
endmodule
